// File: rtl/level_select_fsm_pkg.sv
// Shared level encoding for the level controller, display and scroll-speed blocks.
package level_select_fsm_pkg;

  localparam int LEVEL_FIRST    = 0;
  localparam int DEF_NUM_LEVELS = 4;
  localparam int DEF_LEVEL_W    = 2;

  // The last level index is endless mode.
  function automatic int endless_idx(input int num_levels);
    return num_levels - 1;
  endfunction

endpackage

// File: rtl/level_step.sv
// Candidate next level for a next/prev press against a movable top; wraps or saturates.
// Purely combinational; simultaneous next and prev cancel.
module level_step
  import level_select_fsm_pkg::*;
#(
  parameter int LEVEL_W = DEF_LEVEL_W,
  parameter int WRAP    = 1
) (
  input  logic [LEVEL_W-1:0] level,
  input  logic [LEVEL_W-1:0] top,
  input  logic               next,
  input  logic               prev,
  output logic [LEVEL_W-1:0] cand
);

  localparam logic [LEVEL_W:0]   FIRST_X = (LEVEL_W+1)'(LEVEL_FIRST);
  localparam logic [LEVEL_W:0]   ONE_X   = (LEVEL_W+1)'(1);
  localparam logic [LEVEL_W-1:0] FIRST   = LEVEL_W'(LEVEL_FIRST);

  logic [LEVEL_W:0] lvl_x;
  logic [LEVEL_W:0] top_x;

  assign lvl_x = {1'b0, level};
  assign top_x = {1'b0, top};

  always_comb begin
    cand = level;
    if (next && !prev) begin
      // >= rather than == so a level above a lowered top still wraps/holds
      if (lvl_x >= top_x) cand = (WRAP != 0) ? FIRST : level;
      else                cand = LEVEL_W'(lvl_x + ONE_X);
    end else if (prev && !next) begin
      if (lvl_x == FIRST_X) cand = (WRAP != 0) ? top : level;
      else                  cand = LEVEL_W'(lvl_x - ONE_X);
    end
  end

endmodule

// File: rtl/level_select_fsm.sv
// Level controller: steps on next/prev (blocked by lock), auto-advances on level_clear.
// Optional LEVEL_UNLOCK_EN: levels are unlocked by clearing them; next/prev limited to max_level.
module level_select_fsm
  import level_select_fsm_pkg::*;
#(
  parameter int NUM_LEVELS  = DEF_NUM_LEVELS,
  parameter int LEVEL_W     = DEF_LEVEL_W,
  parameter int WRAP        = 1,
  parameter int RESET_LEVEL = LEVEL_FIRST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  next_press,
  input  logic                  prev_press,
  input  logic                  lock,
  input  logic                  level_clear,
  output logic [LEVEL_W-1:0]    level,
  output logic [NUM_LEVELS-1:0] level_onehot,
  output logic                  endless,
  output logic                  level_chg,
  output logic [LEVEL_W-1:0]    max_level
);

  localparam logic [LEVEL_W-1:0] RST_LVL  = LEVEL_W'(RESET_LEVEL);
  localparam logic [LEVEL_W-1:0] LAST_LVL = LEVEL_W'(endless_idx(NUM_LEVELS));
  localparam logic [LEVEL_W:0]   NUM_X    = (LEVEL_W+1)'(NUM_LEVELS);
  localparam logic [LEVEL_W:0]   LAST_X   = (LEVEL_W+1)'(endless_idx(NUM_LEVELS));
  localparam logic [LEVEL_W:0]   ONE_X    = (LEVEL_W+1)'(1);

  logic [LEVEL_W-1:0] level_q;
  logic               level_chg_q;
  logic [LEVEL_W-1:0] level_d;
  logic               level_chg_d;
  logic [LEVEL_W-1:0] step_lvl;
  logic [LEVEL_W-1:0] top;
  logic [LEVEL_W:0]   lvl_x;
  logic               illegal;

  assign lvl_x   = {1'b0, level_q};
  assign illegal = (lvl_x >= NUM_X);

`ifdef LEVEL_UNLOCK_EN
  logic [LEVEL_W-1:0] max_q;
  logic [LEVEL_W-1:0] unlock_cand;

  always_comb begin
    unlock_cand = LAST_LVL;
    if (lvl_x < LAST_X) unlock_cand = LEVEL_W'(lvl_x + ONE_X);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= RST_LVL;
    end else if (level_clear && !illegal && (unlock_cand > max_q)) begin
      max_q <= unlock_cand;
    end
  end

  assign top = max_q;
`else
  assign top = LAST_LVL;
`endif

  assign max_level = top;

  level_step #(
    .LEVEL_W (LEVEL_W),
    .WRAP    (WRAP)
  ) u_step (
    .level (level_q),
    .top   (top),
    .next  (next_press),
    .prev  (prev_press),
    .cand  (step_lvl)
  );

  always_comb begin
    level_d = level_q;
    if (illegal) begin
      level_d = RST_LVL;
    end else if (level_clear) begin
      if (lvl_x < LAST_X) level_d = LEVEL_W'(lvl_x + ONE_X);
    end else if (!lock) begin
      level_d = step_lvl;
    end
    level_chg_d = (level_d != level_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q     <= RST_LVL;
      level_chg_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      level_chg_q <= level_chg_d;
    end
  end

  always_comb begin
    level_onehot = '0;
    for (int i = 0; i < NUM_LEVELS; i++) level_onehot[i] = (level_q == LEVEL_W'(i));
  end

  assign endless   = (level_q == LAST_LVL);
  assign level     = level_q;
  assign level_chg = level_chg_q;

endmodule

// File: tb/tb_level_select_fsm.sv
// Directed bench: three instances (4 levels wrap, 4 levels saturate, 3 levels wrap) share stimulus.
module tb_level_select_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic next_press = 1'b0;
  logic prev_press = 1'b0;
  logic lock = 1'b0;
  logic level_clear = 1'b0;

  logic [1:0] a_level, b_level, c_level;
  logic [3:0] a_onehot, b_onehot;
  logic [2:0] c_onehot;
  logic       a_endless, b_endless, c_endless;
  logic       a_chg, b_chg, c_chg;
  logic [1:0] a_max, b_max, c_max;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  level_select_fsm #(.NUM_LEVELS(4), .LEVEL_W(2), .WRAP(1), .RESET_LEVEL(0)) u_a (
    .clk(clk), .rst_n(rst_n), .next_press(next_press), .prev_press(prev_press),
    .lock(lock), .level_clear(level_clear), .level(a_level), .level_onehot(a_onehot),
    .endless(a_endless), .level_chg(a_chg), .max_level(a_max));

  level_select_fsm #(.NUM_LEVELS(4), .LEVEL_W(2), .WRAP(0), .RESET_LEVEL(0)) u_b (
    .clk(clk), .rst_n(rst_n), .next_press(next_press), .prev_press(prev_press),
    .lock(lock), .level_clear(level_clear), .level(b_level), .level_onehot(b_onehot),
    .endless(b_endless), .level_chg(b_chg), .max_level(b_max));

  level_select_fsm #(.NUM_LEVELS(3), .LEVEL_W(2), .WRAP(1), .RESET_LEVEL(0)) u_c (
    .clk(clk), .rst_n(rst_n), .next_press(next_press), .prev_press(prev_press),
    .lock(lock), .level_clear(level_clear), .level(c_level), .level_onehot(c_onehot),
    .endless(c_endless), .level_chg(c_chg), .max_level(c_max));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the capturing edge.
  task automatic step(input logic n, input logic p, input logic c);
    @(negedge clk);
    next_press  = n;
    prev_press  = p;
    level_clear = c;
    @(posedge clk);
    #1;
    next_press  = 1'b0;
    prev_press  = 1'b0;
    level_clear = 1'b0;
  endtask

  logic [1:0] b_exp_lvl [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  logic       b_exp_chg [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_level", a_level, 0);
    check("rst_a_chg", a_chg, 0);
    check("rst_a_onehot", a_onehot, 4'b0001);
    check("rst_a_endless", a_endless, 0);
`ifdef LEVEL_UNLOCK_EN
    check("rst_a_max", a_max, 0);
`else
    check("rst_a_max", a_max, 3);
    check("rst_c_max", c_max, 2);
`endif
    @(negedge clk);
    rst_n = 1'b1;

`ifdef LEVEL_UNLOCK_EN
    step(1, 0, 0);
    check("unl_next0_level", a_level, 0);
    check("unl_next0_chg", a_chg, 0);
    check("unl_next0_max", a_max, 0);
    step(0, 0, 1);
    check("unl_clear_level", a_level, 1);
    check("unl_clear_chg", a_chg, 1);
    check("unl_clear_max", a_max, 1);
    step(1, 0, 0);
    check("unl_next1_level", a_level, 0);
    check("unl_next1_chg", a_chg, 1);
    step(0, 1, 0);
    check("unl_prev0_level", a_level, 1);
`else
    step(1, 0, 0);
    check("n1_a_level", a_level, 1);
    check("n1_a_chg", a_chg, 1);
    check("n1_a_onehot", a_onehot, 4'b0010);
    step(1, 0, 0);
    check("n2_a_level", a_level, 2);
    check("n2_a_endless", a_endless, 0);
    step(1, 0, 0);
    check("n3_a_level", a_level, 3);
    check("n3_a_endless", a_endless, 1);
    check("n3_a_onehot", a_onehot, 4'b1000);
    check("n3_c_wrap_level", c_level, 0);
    check("n3_c_chg", c_chg, 1);
    step(1, 0, 0);
    check("n4_a_wrap_level", a_level, 0);
    check("n4_a_chg", a_chg, 1);
    check("n4_a_endless", a_endless, 0);
    check("n4_b_sat_level", b_level, 3);
    check("n4_b_sat_chg", b_chg, 0);
    step(0, 0, 0);
    check("idle_a_chg", a_chg, 0);

    step(0, 1, 0);
    check("p1_a_wrap_level", a_level, 3);
    check("p1_b_level", b_level, 2);
    step(0, 1, 0);
    step(0, 1, 0);
    check("p3_b_level", b_level, 0);
    step(0, 1, 0);
    check("p4_a_level", a_level, 0);
    check("p4_b_sat_level", b_level, 0);
    check("p4_b_sat_chg", b_chg, 0);

    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      check($sformatf("b_sat_next%0d_level", i), b_level, b_exp_lvl[i]);
      check($sformatf("b_sat_next%0d_chg", i), b_chg, b_exp_chg[i]);
    end
    check("loop_a_level", a_level, 1);

    lock = 1'b1;
    step(1, 0, 0);
    check("lock_next_level", a_level, 1);
    check("lock_next_chg", a_chg, 0);
    step(0, 1, 0);
    check("lock_prev_level", a_level, 1);
    step(0, 0, 1);
    check("lock_clear_a_level", a_level, 2);
    check("lock_clear_a_chg", a_chg, 1);
    check("lock_clear_b_endless_level", b_level, 3);
    check("lock_clear_b_endless_chg", b_chg, 0);
    check("lock_clear_c_endless_chg", c_chg, 0);
    step(0, 0, 1);
    check("clear_to3_level", a_level, 3);
    step(0, 0, 1);
    check("clear_endless_level", a_level, 3);
    check("clear_endless_chg", a_chg, 0);
    lock = 1'b0;

    step(1, 1, 0);
    check("both_level", a_level, 3);
    check("both_chg", a_chg, 0);
    step(1, 0, 0);
    check("wrap_again_level", a_level, 0);
    step(1, 0, 1);
    check("clear_next_level", a_level, 1);
    check("clear_next_chg", a_chg, 1);
    step(1, 0, 0);
    check("pre_rst_level", a_level, 2);

    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_level", a_level, 0);
    check("midrst_chg", a_chg, 0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    @(negedge clk);
    force u_c.level_q = 2'd3;
    #1;
    release u_c.level_q;
    check("illegal_seen_level", c_level, 3);
    check("illegal_onehot", c_onehot, 3'b000);
    check("illegal_endless", c_endless, 0);
    @(posedge clk);
    #1;
    check("illegal_recover_level", c_level, 0);
    check("illegal_recover_chg", c_chg, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
